multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle MIPS control unit: the next-generation replacement for the single-cycle opcode decoder. A Moore-style FSM sequences each instruction through fetch, decode, execute, memory and write-back steps. It adds a memory ready handshake, load/store and jump support, trapping of illegal opcodes, and a retired-instruction counter. It sits between the instruction register and the shared datapath: one ALU, a unified instruction/data memory, the register file and the PC.

## Interface
- `OP_W`, 6, opcode width
- `ALUOP_W`, 3, ALU-control op width
- `CNT_W`, 16, retired-instruction counter width
- `clk_i` in 1, clock
- `rst_i` in 1, asynchronous, active-low reset
- `start_i` in 1, leave IDLE and begin fetching
- `instr_op_i` in OP_W, opcode field of the IR (valid from DECODE onward)
- `mem_ready_i` in 1, memory access completes this cycle
- `zero_i` in 1, ALU zero flag
- `pc_write_o`, `ir_write_o`, `mem_read_o`, `mem_write_o`, `iord_o`, `reg_write_o`, `reg_dst_o`, `mem_to_reg_o`, `alu_src_a_o` out 1 each, datapath controls
- `alu_src_b_o` out 2, ALU B select: 0=reg B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
- `pc_src_o` out 2, PC source: 0=ALU result, 1=ALUOut register, 2=jump target
- `alu_op_o` out ALUOP_W, op code sent to ALU control
- `state_o` out 4, current state encoding
- `instr_done_o` out 1, one-cycle pulse on the last cycle of each instruction
- `illegal_o` out 1, sticky illegal-opcode flag
- `instr_cnt_o` out CNT_W, retired-instruction count

## Operation
- Opcodes: 0 R-type, 2 J, 4 BEQ, 5 BNE, 8 ADDI, 10 SLTI, 13 ORI, 15 LUI, 35 LW, 43 SW. Any other value is illegal.
- ALU op codes: R=000, add=001, ORI=010, BNE=011, BEQ=100, SLTI=101, LUI=110.
- `op_q` latches `instr_op_i` in DECODE. All later states use `op_q`.
- Every output not listed for a state below is 0.
- IDLE: all outputs 0. Go to FETCH when `start_i`=1.
- FETCH: `mem_read`=1, `iord`=0, `src_a`=0, `src_b`=1, `alu_op`=001, `pc_src`=0. `ir_write` and `pc_write` equal `mem_ready_i`. Stay in FETCH until `mem_ready_i`=1, then go to DECODE.
- DECODE: `src_a`=0, `src_b`=3, `alu_op`=001 (branch target into ALUOut). Next state:
  - 0 → EXEC_R
  - 8, 10, 13, 15 → EXEC_I
  - 35, 43 → MEM_ADDR
  - 4, 5 → BRANCH
  - 2 → JUMP
  - illegal → TRAP
- EXEC_R: `src_a`=1, `src_b`=0, `alu_op`=000. Go to ALU_WB.
- EXEC_I: `src_a`=1, `src_b`=2, `alu_op` per opcode. Go to ALU_WB.
- ALU_WB: `reg_write`=1, `reg_dst`=(`op_q`==0), `mem_to_reg`=0. Instruction done; go to FETCH.
- MEM_ADDR: `src_a`=1, `src_b`=2, `alu_op`=001. Next is MEM_RD for LW, MEM_WR for SW.
- MEM_RD: `iord`=1, `mem_read`=1. Wait for `mem_ready_i`, then go to MEM_WB.
- MEM_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1. Instruction done.
- MEM_WR: `iord`=1, `mem_write`=1. Wait for `mem_ready_i`; the instruction is done on the ready cycle.
- BRANCH: `src_a`=1, `src_b`=0, `alu_op`=100 (BEQ) or 011 (BNE), `pc_src`=1.
  - `pc_write` = `zero_i` for BEQ, `!zero_i` for BNE.
  - Instruction done.
- JUMP: `pc_src`=2, `pc_write`=1. Instruction done.
- TRAP: sets `illegal_o`. No write, memory or PC enable ever asserts again. Held until reset.
- Instruction done: `instr_done_o`=1, `instr_cnt_o` increments mod 2^CNT_W (wraps to 0), next state is FETCH.

## Timing
- Reset values: state IDLE, `op_q`=0, count=0, `illegal_o`=0, all other outputs 0.
- Reset asserted mid-operation (including a pending memory wait) drives all outputs to 0 immediately and abandons the instruction.
- Outputs are combinational from state and `op_q`. The only input-dependent exceptions are `mem_ready_i` (FETCH) and `zero_i` (BRANCH).
- Latency with zero-wait memory:
  - R-type, I-type, SW: 4 cycles
  - LW: 5 cycles
  - BEQ, BNE, J: 3 cycles
- Each cycle of `mem_ready_i`=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- `mem_ready_i` is ignored outside memory states.
- `start_i` is ignored outside IDLE.

## Structure
- Package `ctrl_pkg` holds:
  - opcode localparams
  - ALU op codes
  - `alu_src_b` and `pc_src` encodings
  - state enum (4-bit, exported on `state_o`)
- Sub-module `ctrl_op_class` is combinational: opcode → {class, legal, per-opcode `alu_op`}. It is shared by the DECODE next-state logic and EXEC_I.

## Test plan
- Reset, then `start_i`=1, ADDI, ready always 1 → states FETCH, DECODE, EXEC_I, ALU_WB; `alu_op`=001 in EXEC_I; `reg_write`=1, `reg_dst`=0; count=1.
- LW with `mem_ready_i` low for 2 cycles in MEM_RD → 7-cycle instruction; `mem_to_reg`=1 in MEM_WB; `ir_write` pulses exactly once.
- BEQ with `zero_i`=1 then BNE with `zero_i`=1 → `pc_write`=1 for BEQ and 0 for BNE, `pc_src`=1 in both; 3 cycles each.
- Opcode 63 → TRAP, `illegal_o`=1, all enables 0 for 20 cycles, count frozen.
- Preload count to 2^CNT_W−1 (CNT_W=4, 15 instructions), run J → count wraps to 0, `instr_done_o` pulses once.
- Assert `rst_i`=0 during a FETCH wait → outputs 0 the same cycle; after release, state IDLE until `start_i`.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, ALU ops,
// datapath mux selects, FSM states and opcode classes.
package ctrl_pkg;

  localparam logic [5:0] OpRtype = 6'd0;
  localparam logic [5:0] OpJ     = 6'd2;
  localparam logic [5:0] OpBeq   = 6'd4;
  localparam logic [5:0] OpBne   = 6'd5;
  localparam logic [5:0] OpAddi  = 6'd8;
  localparam logic [5:0] OpSlti  = 6'd10;
  localparam logic [5:0] OpOri   = 6'd13;
  localparam logic [5:0] OpLui   = 6'd15;
  localparam logic [5:0] OpLw    = 6'd35;
  localparam logic [5:0] OpSw    = 6'd43;

  localparam logic [2:0] AluR    = 3'b000;
  localparam logic [2:0] AluAdd  = 3'b001;
  localparam logic [2:0] AluOri  = 3'b010;
  localparam logic [2:0] AluBne  = 3'b011;
  localparam logic [2:0] AluBeq  = 3'b100;
  localparam logic [2:0] AluSlti = 3'b101;
  localparam logic [2:0] AluLui  = 3'b110;

  localparam logic [1:0] SrcBReg   = 2'd0;
  localparam logic [1:0] SrcBFour  = 2'd1;
  localparam logic [1:0] SrcBImm   = 2'd2;
  localparam logic [1:0] SrcBImmSh = 2'd3;

  localparam logic [1:0] PcSrcAlu    = 2'd0;
  localparam logic [1:0] PcSrcAluOut = 2'd1;
  localparam logic [1:0] PcSrcJump   = 2'd2;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StExecR   = 4'd3,
    StExecI   = 4'd4,
    StAluWb   = 4'd5,
    StMemAddr = 4'd6,
    StMemRd   = 4'd7,
    StMemWb   = 4'd8,
    StMemWr   = 4'd9,
    StBranch  = 4'd10,
    StJump    = 4'd11,
    StTrap    = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    ClsR,
    ClsI,
    ClsMem,
    ClsBranch,
    ClsJump,
    ClsIllegal
  } op_class_e;

endpackage

// File: rtl/ctrl_op_class.sv
// Combinational opcode classifier: instruction class, legality and the ALU op
// that the execute-type states send to ALU control.
module ctrl_op_class
  import ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned ALUOP_W = 3
) (
  input  logic [OP_W-1:0]    op_i,
  output op_class_e          cls_o,
  output logic               legal_o,
  output logic [ALUOP_W-1:0] alu_op_o
);

  always_comb begin
    cls_o    = ClsIllegal;
    legal_o  = 1'b1;
    alu_op_o = ALUOP_W'(AluAdd);
    case (op_i)
      OP_W'(OpRtype): begin cls_o = ClsR;      alu_op_o = ALUOP_W'(AluR);    end
      OP_W'(OpAddi):  begin cls_o = ClsI;      alu_op_o = ALUOP_W'(AluAdd);  end
      OP_W'(OpSlti):  begin cls_o = ClsI;      alu_op_o = ALUOP_W'(AluSlti); end
      OP_W'(OpOri):   begin cls_o = ClsI;      alu_op_o = ALUOP_W'(AluOri);  end
      OP_W'(OpLui):   begin cls_o = ClsI;      alu_op_o = ALUOP_W'(AluLui);  end
      OP_W'(OpLw):    cls_o = ClsMem;
      OP_W'(OpSw):    cls_o = ClsMem;
      OP_W'(OpBeq):   begin cls_o = ClsBranch; alu_op_o = ALUOP_W'(AluBeq);  end
      OP_W'(OpBne):   begin cls_o = ClsBranch; alu_op_o = ALUOP_W'(AluBne);  end
      OP_W'(OpJ):     cls_o = ClsJump;
      default:        legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back,
// waits on memory ready, traps illegal opcodes and counts retired instructions.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [OP_W-1:0]    instr_op_i,
  input  logic               mem_ready_i,
  input  logic               zero_i,
  output logic               pc_write_o,
  output logic               ir_write_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               iord_o,
  output logic               reg_write_o,
  output logic               reg_dst_o,
  output logic               mem_to_reg_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [1:0]         pc_src_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic [3:0]         state_o,
  output logic               instr_done_o,
  output logic               illegal_o,
  output logic [CNT_W-1:0]   instr_cnt_o
);

  state_e             state_q, state_d;
  logic [OP_W-1:0]    op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [OP_W-1:0]    cls_op;
  op_class_e          cls;
  logic               cls_legal;
  logic [ALUOP_W-1:0] cls_alu_op;

  // One classifier: live IR opcode while decoding, latched opcode afterwards.
  assign cls_op = (state_q == StDecode) ? instr_op_i : op_q;

  ctrl_op_class #(
    .OP_W    (OP_W),
    .ALUOP_W (ALUOP_W)
  ) u_op_class (
    .op_i     (cls_op),
    .cls_o    (cls),
    .legal_o  (cls_legal),
    .alu_op_o (cls_alu_op)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (start_i) state_d = StFetch;
      StFetch:   if (mem_ready_i) state_d = StDecode;
      StDecode: begin
        if (!cls_legal) begin
          state_d = StTrap;
        end else begin
          case (cls)
            ClsR:      state_d = StExecR;
            ClsI:      state_d = StExecI;
            ClsMem:    state_d = StMemAddr;
            ClsBranch: state_d = StBranch;
            ClsJump:   state_d = StJump;
            default:   state_d = StTrap;
          endcase
        end
      end
      StExecR, StExecI: state_d = StAluWb;
      StMemAddr: state_d = (op_q == OP_W'(OpLw)) ? StMemRd : StMemWr;
      StMemRd:   if (mem_ready_i) state_d = StMemWb;
      StMemWr:   if (mem_ready_i) state_d = StFetch;
      StAluWb, StMemWb, StBranch, StJump: state_d = StFetch;
      StTrap:    state_d = StTrap;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    iord_o       = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SrcBReg;
    pc_src_o     = PcSrcAlu;
    alu_op_o     = '0;
    instr_done_o = 1'b0;
    illegal_o    = 1'b0;
    case (state_q)
      StFetch: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SrcBFour;
        alu_op_o    = ALUOP_W'(AluAdd);
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      StDecode: begin
        alu_src_b_o = SrcBImmSh;
        alu_op_o    = ALUOP_W'(AluAdd);
      end
      StExecR: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALUOP_W'(AluR);
      end
      StExecI: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SrcBImm;
        alu_op_o    = cls_alu_op;
      end
      StAluWb: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = (op_q == OP_W'(OpRtype));
        instr_done_o = 1'b1;
      end
      StMemAddr: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SrcBImm;
        alu_op_o    = ALUOP_W'(AluAdd);
      end
      StMemRd: begin
        iord_o     = 1'b1;
        mem_read_o = 1'b1;
      end
      StMemWb: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        instr_done_o = 1'b1;
      end
      StMemWr: begin
        iord_o       = 1'b1;
        mem_write_o  = 1'b1;
        instr_done_o = mem_ready_i;
      end
      StBranch: begin
        alu_src_a_o  = 1'b1;
        alu_op_o     = cls_alu_op;
        pc_src_o     = PcSrcAluOut;
        pc_write_o   = (op_q == OP_W'(OpBeq)) ? zero_i : !zero_i;
        instr_done_o = 1'b1;
      end
      StJump: begin
        pc_src_o     = PcSrcJump;
        pc_write_o   = 1'b1;
        instr_done_o = 1'b1;
      end
      StTrap:  illegal_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) op_q <= instr_op_i;
      if (instr_done_o) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign state_o     = state_q;
  assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected outputs are queued with
// their stimulus and compared mid-cycle as the DUT steps through each instruction.
module tb_multicycle_ctrl;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned CNT_W   = 4;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               start_i;
  logic [OP_W-1:0]    instr_op_i;
  logic               mem_ready_i;
  logic               zero_i;
  logic               pc_write_o, ir_write_o, mem_read_o, mem_write_o, iord_o;
  logic               reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o;
  logic [1:0]         alu_src_b_o, pc_src_o;
  logic [ALUOP_W-1:0] alu_op_o;
  logic [3:0]         state_o;
  logic               instr_done_o, illegal_o;
  logic [CNT_W-1:0]   instr_cnt_o;

  multicycle_ctrl #(
    .OP_W    (OP_W),
    .ALUOP_W (ALUOP_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .instr_op_i   (instr_op_i),
    .mem_ready_i  (mem_ready_i),
    .zero_i       (zero_i),
    .pc_write_o   (pc_write_o),
    .ir_write_o   (ir_write_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .iord_o       (iord_o),
    .reg_write_o  (reg_write_o),
    .reg_dst_o    (reg_dst_o),
    .mem_to_reg_o (mem_to_reg_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .pc_src_o     (pc_src_o),
    .alu_op_o     (alu_op_o),
    .state_o      (state_o),
    .instr_done_o (instr_done_o),
    .illegal_o    (illegal_o),
    .instr_cnt_o  (instr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // {state, pcw, irw, mrd, mwr, iord, regw, regdst, m2r, srca, srcb, pcsrc, aluop, done, ill, cnt}
  logic [25:0] act;
  assign act = {state_o, pc_write_o, ir_write_o, mem_read_o, mem_write_o, iord_o,
                reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, pc_src_o,
                alu_op_o, instr_done_o, illegal_o, instr_cnt_o};

  typedef struct {
    logic        start;
    logic [5:0]  op;
    logic        rdy;
    logic        zero;
    logic [25:0] exp;
  } item_t;

  item_t      q[$];
  logic [3:0] model_cnt = '0;
  int         checks    = 0;
  int         failures  = 0;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic push(input logic s, input logic [5:0] op, input logic r, input logic z,
                      input logic [3:0] st, input logic [8:0] en, input logic [1:0] sb,
                      input logic [1:0] ps, input logic [2:0] al, input logic dn,
                      input logic il);
    item_t it;
    it.start = s;
    it.op    = op;
    it.rdy   = r;
    it.zero  = z;
    it.exp   = {st, en, sb, ps, al, dn, il, model_cnt};
    q.push_back(it);
    if (dn) model_cnt = model_cnt + 4'd1;
  endtask

  task automatic push_idle(input logic s);
    push(s, 6'($urandom), rb(), rb(), 4'd0, 9'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
  endtask

  // Expected per-cycle sequence of one instruction; opcode goes to junk after DECODE.
  task automatic push_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
    logic [5:0] g;
    logic [2:0] ial;
    g = ~op;
    for (int i = 0; i < fw; i++)
      push(rb(), op, 1'b0, rb(), 4'd1, 9'b001000000, 2'd1, 2'd0, 3'b001, 1'b0, 1'b0);
    push(rb(), op, 1'b1, rb(), 4'd1, 9'b111000000, 2'd1, 2'd0, 3'b001, 1'b0, 1'b0);
    push(rb(), op, rb(), rb(), 4'd2, 9'b000000000, 2'd3, 2'd0, 3'b001, 1'b0, 1'b0);
    case (op)
      6'd0: begin
        push(rb(), g, rb(), rb(), 4'd3, 9'b000000001, 2'd0, 2'd0, 3'b000, 1'b0, 1'b0);
        push(rb(), g, rb(), rb(), 4'd5, 9'b000001100, 2'd0, 2'd0, 3'b000, 1'b1, 1'b0);
      end
      6'd8, 6'd10, 6'd13, 6'd15: begin
        ial = (op == 6'd8) ? 3'b001 : (op == 6'd10) ? 3'b101 : (op == 6'd13) ? 3'b010 : 3'b110;
        push(rb(), g, rb(), rb(), 4'd4, 9'b000000001, 2'd2, 2'd0, ial, 1'b0, 1'b0);
        push(rb(), g, rb(), rb(), 4'd5, 9'b000001000, 2'd0, 2'd0, 3'b000, 1'b1, 1'b0);
      end
      6'd35: begin
        push(rb(), g, rb(), rb(), 4'd6, 9'b000000001, 2'd2, 2'd0, 3'b001, 1'b0, 1'b0);
        for (int i = 0; i < mw; i++)
          push(rb(), g, 1'b0, rb(), 4'd7, 9'b001010000, 2'd0, 2'd0, 3'b000, 1'b0, 1'b0);
        push(rb(), g, 1'b1, rb(), 4'd7, 9'b001010000, 2'd0, 2'd0, 3'b000, 1'b0, 1'b0);
        push(rb(), g, rb(), rb(), 4'd8, 9'b000001010, 2'd0, 2'd0, 3'b000, 1'b1, 1'b0);
      end
      6'd43: begin
        push(rb(), g, rb(), rb(), 4'd6, 9'b000000001, 2'd2, 2'd0, 3'b001, 1'b0, 1'b0);
        for (int i = 0; i < mw; i++)
          push(rb(), g, 1'b0, rb(), 4'd9, 9'b000110000, 2'd0, 2'd0, 3'b000, 1'b0, 1'b0);
        push(rb(), g, 1'b1, rb(), 4'd9, 9'b000110000, 2'd0, 2'd0, 3'b000, 1'b1, 1'b0);
      end
      6'd4, 6'd5: begin
        push(rb(), g, rb(), z, 4'd10, {(op == 6'd4) ? z : !z, 8'b00000001}, 2'd0, 2'd1,
             (op == 6'd4) ? 3'b100 : 3'b011, 1'b1, 1'b0);
      end
      6'd2: push(rb(), g, rb(), rb(), 4'd11, 9'b100000000, 2'd0, 2'd2, 3'b000, 1'b1, 1'b0);
      default: begin
        for (int i = 0; i < 20; i++)
          push(rb(), 6'($urandom), rb(), rb(), 4'd12, 9'b0, 2'd0, 2'd0, 3'b000, 1'b0, 1'b1);
      end
    endcase
  endtask

  // Entered and left just after a rising edge.
  task automatic run_queue(input string name);
    item_t it;
    int    cyc;
    cyc = 0;
    while (q.size() > 0) begin
      it          = q.pop_front();
      start_i     = it.start;
      instr_op_i  = it.op;
      mem_ready_i = it.rdy;
      zero_i      = it.zero;
      @(negedge clk_i);
      checks++;
      if (act !== it.exp) begin
        failures++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, it.exp);
      end
      cyc++;
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0; start_i = 1'b0; instr_op_i = '0; mem_ready_i = 1'b0; zero_i = 1'b0;
    #2;
    checks++;
    if (act !== 26'd0) begin
      failures++;
      $display("FAIL reset_initial: got %h expected 0", act);
    end
    start_i = 1'b1; mem_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (act !== 26'd0) begin
      failures++;
      $display("FAIL reset_held: got %h expected 0", act);
    end
    start_i = 1'b0;
    rst_i   = 1'b1;
    @(posedge clk_i);
    #1;
    push_idle(1'b0);
    push_idle(1'b0);
    run_queue("reset_idle");
  endtask

  task automatic test_addi();
    push_idle(1'b1);
    push_instr(6'd8, 1'b0, 0, 0);
    run_queue("addi");
  endtask

  task automatic test_lw_wait();
    push_instr(6'd35, 1'b0, 0, 2);
    run_queue("lw_wait");
  endtask

  task automatic test_branch();
    push_instr(6'd4, 1'b1, 0, 0);
    push_instr(6'd5, 1'b1, 0, 0);
    push_instr(6'd4, 1'b0, 0, 0);
    push_instr(6'd5, 1'b0, 0, 0);
    run_queue("branch");
  endtask

  task automatic test_mix();
    push_instr(6'd0, 1'b0, 1, 0);
    push_instr(6'd10, 1'b0, 0, 0);
    push_instr(6'd13, 1'b0, 2, 0);
    push_instr(6'd15, 1'b0, 0, 0);
    push_instr(6'd43, 1'b0, 1, 3);
    run_queue("mix");
  endtask

  task automatic test_count_wrap();
    while (model_cnt != 4'd15) push_instr(6'd2, 1'b0, 0, 0);
    run_queue("count_preload");
    push_instr(6'd2, 1'b0, 0, 0);
    push_instr(6'd0, 1'b0, 0, 0);
    run_queue("count_wrap");
  endtask

  task automatic test_reset_mid_fetch();
    start_i = 1'b0; mem_ready_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (state_o !== 4'd1 || mem_read_o !== 1'b1) begin
      failures++;
      $display("FAIL fetch_wait: got state %0d mem_read %b expected 1 1", state_o, mem_read_o);
    end
    #2 rst_i = 1'b0;
    #1;
    checks++;
    if (act !== 26'd0) begin
      failures++;
      $display("FAIL reset_mid_fetch: got %h expected 0", act);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    model_cnt = '0;
    @(posedge clk_i);
    #1;
    push_idle(1'b0);
    push_idle(1'b0);
    push_idle(1'b0);
    push_idle(1'b1);
    push_instr(6'd43, 1'b0, 1, 1);
    push_instr(6'd35, 1'b0, 0, 0);
    run_queue("after_reset");
  endtask

  task automatic test_trap();
    push_instr(6'd63, 1'b0, 0, 0);
    run_queue("trap");
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw_wait();
    test_branch();
    test_mix();
    test_count_wrap();
    test_reset_mid_fetch();
    test_trap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
